// File: rtl/mycpu_pkg.sv
// Shared types and constants for the instruction fetch path.
package mycpu_pkg;

  typedef enum logic [1:0] {
    PS_HOLD   = 2'b00,
    PS_INC    = 2'b01,
    PS_BRANCH = 2'b10,
    PS_JUMP   = 2'b11
  } pc_sel_t;

  typedef enum logic {
    IF_IDLE = 1'b0,
    IF_WAIT = 1'b1
  } if_state_t;

  localparam logic [15:0] PC_RESET = 16'h0000;

  // Branch displacement is a 6-bit two's complement field taken from the IR.
  function automatic logic [15:0] sext_br_off(input logic [5:0] field);
    return {{10{field[5]}}, field};
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter register and next-PC select; updates only when enabled.
module fetch_pc
  import mycpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_en,
  input  logic [1:0]  ps_in,
  input  logic [5:0]  br_field,
  input  logic [15:0] a_in,
  output logic [15:0] pc_out
);

  pc_sel_t     ps;
  logic [15:0] pc_q;
  logic [15:0] pc_d;

  assign ps = pc_sel_t'(ps_in);

  // All additions wrap modulo 2^16 by virtue of the 16-bit result.
  always_comb begin
    pc_d = pc_q;
    case (ps)
      PS_INC:    pc_d = pc_q + 16'd1;
      PS_BRANCH: pc_d = pc_q + sext_br_off(br_field);
      PS_JUMP:   pc_d = a_in;
      default:   pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= PC_RESET;
    end else if (pc_en) begin
      pc_q <= pc_d;
    end
  end

  assign pc_out = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: request FSM, instruction register, PC sub-module and
// optional taken-branch counter (enabled by defining MYCPU_BRCNT_EN).
//
// state   | meaning
// IF_IDLE | no fetch outstanding; a load request with valid data completes in-cycle
// IF_WAIT | fetch issued, holding request until memory returns valid data
module fetch_unit
  import mycpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  ps_in,
  input  logic        il_in,
  input  logic [15:0] a_in,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic [15:0] ir_out,
  output logic [15:0] pc_out,
  output logic        stall_out,
  output logic [15:0] bcnt_out
);

  if_state_t   state_q;
  if_state_t   state_d;
  logic        ir_load;
  logic        pc_en;
  logic [15:0] ir_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IF_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IF_IDLE: if (il_in && !imem_valid) state_d = IF_WAIT;
      IF_WAIT: if (imem_valid)           state_d = IF_IDLE;
      default:                           state_d = IF_IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state_q == IF_WAIT) || ((state_q == IF_IDLE) && il_in);
    stall_out = imem_req && !imem_valid;
    ir_load   = imem_req && imem_valid;
    pc_en     = !stall_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q <= 16'h0000;
    end else if (ir_load) begin
      ir_q <= imem_rdata;
    end
  end

  fetch_pc u_fetch_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .pc_en    (pc_en),
    .ps_in    (ps_in),
    .br_field ({ir_q[8:6], ir_q[2:0]}),
    .a_in     (a_in),
    .pc_out   (pc_out)
  );

  assign imem_addr = pc_out;
  assign ir_out    = ir_q;

`ifdef MYCPU_BRCNT_EN
  logic [15:0] bcnt_q;

  // Counts applied branch/jump updates (ps_in[1] set), saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q <= 16'h0000;
    end else if (pc_en && ps_in[1] && (bcnt_q != 16'hFFFF)) begin
      bcnt_q <= bcnt_q + 16'd1;
    end
  end

  assign bcnt_out = bcnt_q;
`else
  assign bcnt_out = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; completed fetches are checked by a scoreboard monitor.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  ps_in;
  logic        il_in;
  logic [15:0] a_in;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic [15:0] ir_out;
  logic [15:0] pc_out;
  logic        stall_out;
  logic [15:0] bcnt_out;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_ir_q[$];
  bit          pending = 1'b0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps_in      (ps_in),
    .il_in      (il_in),
    .a_in       (a_in),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .ir_out     (ir_out),
    .pc_out     (pc_out),
    .stall_out  (stall_out),
    .bcnt_out   (bcnt_out)
  );

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_bc(input int n);
`ifdef MYCPU_BRCNT_EN
    return 16'(n);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A fetch completes on the edge after req && valid is seen; compare IR one half-cycle later.
  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 1'b0;
    end else begin
      if (pending) begin
        pending = 1'b0;
        if (exp_ir_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL ir_unexpected_fetch: got 0x%h with no expected entry", ir_out);
        end else begin
          check16("ir_fetch", ir_out, exp_ir_q.pop_front());
        end
      end
      if (imem_req && imem_valid) pending = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ps_in = 2'b00; il_in = 1'b0; a_in = 16'h0000;
    imem_rdata = 16'h0000; imem_valid = 1'b0;
    #12;
    check16("rst_pc",    pc_out,    16'h0000);
    check16("rst_ir",    ir_out,    16'h0000);
    check16("rst_bcnt",  bcnt_out,  16'h0000);
    check16("rst_req",   {15'b0, imem_req},  16'h0000);
    check16("rst_stall", {15'b0, stall_out}, 16'h0000);
    rst_n = 1'b1;
    step();

    // zero-wait fetch
    il_in = 1'b1; imem_valid = 1'b1; imem_rdata = 16'h1234;
    exp_ir_q.push_back(16'h1234);
    #1;
    check16("zw_req",   {15'b0, imem_req},  16'h0001);
    check16("zw_stall", {15'b0, stall_out}, 16'h0000);
    step();
    check16("zw_pc", pc_out, 16'h0000);
    il_in = 1'b0; imem_valid = 1'b0;

    // three wait cycles; increment requested during stall must be dropped
    il_in = 1'b1; imem_rdata = 16'hABCD; ps_in = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      check16("wait_stall", {15'b0, stall_out}, 16'h0001);
      check16("wait_addr",  imem_addr, 16'h0000);
      step();
      check16("wait_pc", pc_out, 16'h0000);
    end
    ps_in = 2'b00; imem_valid = 1'b1;
    exp_ir_q.push_back(16'hABCD);
    #1;
    check16("wait_done_stall", {15'b0, stall_out}, 16'h0000);
    step();
    check16("wait_done_pc", pc_out, 16'h0000);
    il_in = 1'b0; imem_valid = 1'b0;

    // fetch from pre-update PC while jumping to 0x0010 in the same cycle
    il_in = 1'b1; imem_valid = 1'b1; imem_rdata = 16'h01C6; ps_in = 2'b11; a_in = 16'h0010;
    exp_ir_q.push_back(16'h01C6);
    #1;
    check16("jf_addr", imem_addr, 16'h0000);
    step();
    check16("jf_pc",   pc_out,   16'h0010);
    check16("jf_bcnt", bcnt_out, exp_bc(1));
    il_in = 1'b0; imem_valid = 1'b0; ps_in = 2'b10;
    step();
    check16("br_neg2_pc",   pc_out,   16'h000E);
    check16("br_neg2_bcnt", bcnt_out, exp_bc(2));

    // increment wrap at 0xFFFF
    ps_in = 2'b11; a_in = 16'hFFFF;
    step();
    check16("jmp_ffff_pc", pc_out, 16'hFFFF);
    ps_in = 2'b01;
    step();
    check16("inc_wrap_pc",   pc_out,   16'h0000);
    check16("inc_wrap_bcnt", bcnt_out, exp_bc(3));

    ps_in = 2'b11; a_in = 16'h0200;
    step();
    check16("jmp_200_pc",   pc_out,   16'h0200);
    check16("jmp_200_bcnt", bcnt_out, exp_bc(4));

    // branch by -1 from 0x0000 wraps to 0xFFFF
    ps_in = 2'b11; a_in = 16'h0000; il_in = 1'b1; imem_valid = 1'b1; imem_rdata = 16'h01C7;
    exp_ir_q.push_back(16'h01C7);
    step();
    check16("jmp_0_pc", pc_out, 16'h0000);
    il_in = 1'b0; imem_valid = 1'b0; ps_in = 2'b10;
    step();
    check16("br_wrap_pc",   pc_out,   16'hFFFF);
    check16("br_wrap_bcnt", bcnt_out, exp_bc(6));
    ps_in = 2'b00;

    // valid without a request is ignored
    imem_valid = 1'b1; imem_rdata = 16'h5555;
    #1;
    check16("novreq_req", {15'b0, imem_req}, 16'h0000);
    step();
    imem_valid = 1'b0;
    check16("novreq_ir", ir_out, 16'h01C7);

    // reset while waiting abandons the fetch; late valid is ignored
    il_in = 1'b1; imem_rdata = 16'h0000;
    step();
    il_in = 1'b0;
    #1;
    check16("rw_stall", {15'b0, stall_out}, 16'h0001);
    #1;
    rst_n = 1'b0;
    #1;
    check16("rw_ir",    ir_out,   16'h0000);
    check16("rw_pc",    pc_out,   16'h0000);
    check16("rw_bcnt",  bcnt_out, 16'h0000);
    check16("rw_req",   {15'b0, imem_req}, 16'h0000);
    #3;
    rst_n = 1'b1;
    imem_valid = 1'b1; imem_rdata = 16'hDEAD;
    step();
    step();
    check16("late_ir",    ir_out, 16'h0000);
    check16("late_req",   {15'b0, imem_req},  16'h0000);
    check16("late_stall", {15'b0, stall_out}, 16'h0000);
    imem_valid = 1'b0;
    step();
    check16("scoreboard_empty", 16'(exp_ir_q.size()), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
- REQ-001 SHALL have ports: clk in 1, clock; all state updates on rising edge.
- REQ-002 SHALL have ports: rst_n in 1, asynchronous, active-low reset.
- REQ-003 SHALL have ports: ps_in in 2, PC select from control unit: 00 hold, 01 increment, 10 branch, 11 jump.
- REQ-004 SHALL have ports: il_in in 1, instruction-load request from control unit.
- REQ-005 SHALL have ports: a_in in 16, register-file A bus, jump target.
- REQ-006 SHALL have ports: imem_addr out 16, instruction memory address.
- REQ-007 SHALL have ports: imem_req out 1, memory read request.
- REQ-008 SHALL have ports: imem_rdata in 16, memory read data.
- REQ-009 SHALL have ports: imem_valid in 1, memory read data valid.
- REQ-010 SHALL have ports: ir_out out 16, instruction register, drives control-unit instruction input.
- REQ-011 SHALL have ports: pc_out out 16, program counter.
- REQ-012 SHALL have ports: stall_out out 1, fetch pending; top level holds control-unit state while high.
- REQ-013 SHALL have ports: bcnt_out out 16, taken branch/jump count.

Function
- REQ-014 SHALL implement FSM states IF_IDLE and IF_WAIT.
- REQ-015 imem_req SHALL be asserted combinationally when (IF_IDLE and il_in) or IF_WAIT; imem_addr SHALL equal pc_out.
- REQ-016 stall_out SHALL equal imem_req and not imem_valid.
- REQ-017 IF_IDLE, il_in=1, imem_valid=1: ir_out <= imem_rdata at edge, stay IF_IDLE (zero-wait fetch, no stall).
- REQ-018 IF_IDLE, il_in=1, imem_valid=0: go IF_WAIT; ir_out unchanged.
- REQ-019 IF_WAIT, imem_valid=1: ir_out <= imem_rdata, go IF_IDLE; imem_valid=0: stay IF_WAIT, il_in ignored.
- REQ-020 imem_valid while imem_req=0 SHALL be ignored.
- REQ-021 PC update SHALL occur only when stall_out=0: 01 -> PC+1; 10 -> PC + sign-extend16({ir_out[8:6], ir_out[2:0]}); 11 -> a_in; 00 -> hold.
- REQ-022 PC arithmetic SHALL be modulo 2^16 (0xFFFF+1 -> 0x0000; 0x0000 + (-1) -> 0xFFFF).
- REQ-023 il_in and non-zero ps_in in the same unstalled cycle: IR fetched from pre-update PC, PC updated same edge.
- REQ-024 ps_in while stall_out=1 SHALL be discarded, not queued.

Reset
- REQ-025 On rst_n low, asynchronously: pc_out=PC_RESET (0x0000), ir_out=0x0000, state IF_IDLE, bcnt_out=0; imem_req and stall_out SHALL then be 0 unless il_in=1.
- REQ-026 Reset during IF_WAIT SHALL abandon the fetch; a late imem_valid after release SHALL be ignored per REQ-020.

Configuration
- REQ-027 Macro MYCPU_BRCNT_EN defined: bcnt_out SHALL increment on each applied PC update with ps_in 10 or 11, saturating at 0xFFFF.
- REQ-028 Macro MYCPU_BRCNT_EN undefined: bcnt_out SHALL be constant 0 and no counter register SHALL exist; port remains.

Structure
- REQ-029 mycpu_pkg SHALL hold pc_sel_t (PS_HOLD, PS_INC, PS_BRANCH, PS_JUMP), if_state_t, PC_RESET.
- REQ-030 PC register and next-PC mux SHALL be sub-module fetch_pc; fetch_unit holds FSM, IR and counter.

Verification
- REQ-031 Reset, then il_in=1 with imem_valid=1, rdata=0x1234 -> ir_out=0x1234 next edge, stall_out never high, pc_out=0x0000.
- REQ-032 il_in=1, imem_valid low 3 cycles then high with 0xABCD -> stall_out high 3 cycles, imem_addr stable, ir_out=0xABCD, PC unchanged despite ps_in=01 during stall.
- REQ-033 pc=0x0010, ir_out[8:6]=3'b111, ir_out[2:0]=3'b110, ps_in=10 -> pc_out=0x000E; pc=0xFFFF, ps_in=01 -> 0x0000.
- REQ-034 a_in=0x0200, ps_in=11 -> pc_out=0x0200; with MYCPU_BRCNT_EN, bcnt_out increments by 1; without, bcnt_out stays 0.
- REQ-035 rst_n low mid IF_WAIT, then imem_valid=1 after release with il_in=0 -> ir_out stays 0x0000, state IF_IDLE.
